// File: rtl/dmem_lsu.sv
// Load/store unit between the memory stage and a 2^AW x 32 data RAM.
// Define MISALIGN_SPLIT_EN to service misaligned accesses as two RAM cycles.
module dmem_lsu #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [31:0]   rsp_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC1,
    S_ACC2,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic          we_q, uns_q, split_q, err_q;
  logic [1:0]    size_q, off_q;
  logic [AW-1:0] k_q;
  logic [31:0]   wdata_q, word0_q, rdata_q, rdata_d;

  logic [1:0]    a_off;
  logic [AW-1:0] a_k;
  logic          a_range_err, a_split, a_err, accept;

  assign a_off       = req_addr[1:0];
  assign a_k         = req_addr[AW+1:2];
  assign a_range_err = (req_addr >> (AW + 2)) != 32'd0;
  assign accept      = req_valid && req_ready;

`ifdef MISALIGN_SPLIT_EN
  // Accesses that fit in one word stay single; a split past the last word is refused.
  assign a_split = ((req_size == 2'b01) && (a_off == 2'd3)) ||
                   ((req_size == 2'b10) && (a_off != 2'd0));
  assign a_err   = (req_size == 2'b11) || a_range_err ||
                   (a_split && (a_k == '1));
`else
  logic a_mis;
  assign a_mis   = ((req_size == 2'b01) && a_off[0]) ||
                   ((req_size == 2'b10) && (a_off != 2'd0));
  assign a_split = 1'b0;
  assign a_err   = (req_size == 2'b11) || a_range_err || a_mis;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = a_err ? S_RESP : S_ACC1;
      S_ACC1: begin
        if (split_q)    state_d = S_ACC2;
        else if (!we_q) state_d = S_WAIT;
        else            state_d = S_RESP;
      end
      S_ACC2: state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT: state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load assembly: word0 is the live RAM data unless a second word follows it.
  logic [63:0] ld_pair;
  logic [31:0] ld_word, ld_ext;

  assign ld_pair = split_q ? {ram_rdata, word0_q} : {32'd0, ram_rdata};
  assign ld_word = 32'(ld_pair >> {off_q, 3'b000});

  always_comb begin
    ld_ext = ld_word;
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_word[7]}}, ld_word[7:0]};
      2'b01:   ld_ext = {{16{~uns_q & ld_word[15]}}, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    if (state_q == S_WAIT) rdata_d = ld_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      k_q     <= '0;
      wdata_q <= '0;
      word0_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        split_q <= a_split;
        err_q   <= a_err;
        size_q  <= req_size;
        off_q   <= a_off;
        k_q     <= a_k;
        wdata_q <= req_wdata;
      end
      if (state_q == S_ACC2) word0_q <= ram_rdata;
    end
  end

  logic [3:0]  mask;
  logic [6:0]  lanes;
  logic [31:0] wdata_rot;
  logic        in_acc1, in_acc2;

  always_comb begin
    mask = 4'b1111;
    case (size_q)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  assign lanes     = 7'({3'b000, mask} << off_q);
  assign wdata_rot = 32'({wdata_q, wdata_q} >> (6'd32 - {1'b0, off_q, 3'b000}));
  assign in_acc1   = (state_q == S_ACC1) && !rst;
  assign in_acc2   = (state_q == S_ACC2) && !rst;

  always_comb begin
    ram_en    = in_acc1 || in_acc2;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (in_acc1) begin
      ram_addr  = k_q;
      ram_wdata = wdata_rot;
      if (we_q) ram_we = lanes[3:0];
    end else if (in_acc2) begin
      ram_addr  = k_q + 1'b1;
      ram_wdata = wdata_rot;
      if (we_q) ram_we = {1'b0, lanes[6:4]};
    end
  end

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = (state_q == S_RESP) && !rst;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural RAM; expectations follow MISALIGN_SPLIT_EN.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int errors = 0;
  int checks = 0;

  dmem_lsu #(.AW(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  logic [31:0] rd_q = '0;
  assign ram_rdata = rd_q;

  always @(posedge clk) begin
    if (ram_en) begin
      rd_q <= mem[ram_addr];
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          lat;
    int          en_cnt;
    logic [11:0] addr1;
    logic [3:0]  we1;
    logic [3:0]  we2;
    logic [31:0] wd1;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic err, int lat, int en_cnt,
                              logic [11:0] addr1, logic [3:0] we1, logic [3:0] we2,
                              logic [31:0] wd1, logic [31:0] rdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.err = err; v.lat = lat; v.en_cnt = en_cnt; v.addr1 = addr1;
    v.we1 = we1; v.we2 = we2; v.wd1 = wd1; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int c = 0;
    while (!req_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!req_ready) chk({nm, ".ready_timeout"}, 32'(req_ready), 32'd1);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string       nm;
    int          lat_s = 0;
    int          en_s = 0;
    logic [11:0] a1 = '0;
    logic [3:0]  w1 = '0, w2 = '0;
    logic [31:0] wd1 = '0, rd_s = '0;
    logic        err_s = 1'b0, ready_bad = 1'b0;
    nm = $sformatf("v%0d", idx);
    wait_ready(nm);
    issue(v.we, v.size, v.uns, v.addr, v.wdata);
    for (int cy = 1; cy <= 8 && lat_s == 0; cy++) begin
      if (cy > 1) @(negedge clk);
      if (req_ready) ready_bad = 1'b1;
      if (ram_en) begin
        en_s++;
        if (en_s == 1) begin a1 = ram_addr; w1 = ram_we; wd1 = ram_wdata; end
        else w2 = ram_we;
      end
      if (rsp_valid) begin lat_s = cy; err_s = rsp_err; rd_s = rsp_rdata; end
    end
    chk({nm, ".lat"}, 32'(lat_s), 32'(v.lat));
    chk({nm, ".err"}, 32'(err_s), 32'(v.err));
    chk({nm, ".rdata"}, rd_s, v.rdata);
    chk({nm, ".en_cnt"}, 32'(en_s), 32'(v.en_cnt));
    chk({nm, ".ready_busy"}, 32'(ready_bad), 32'd0);
    if (v.en_cnt > 0) begin
      chk({nm, ".addr1"}, 32'(a1), 32'(v.addr1));
      chk({nm, ".we1"}, 32'(w1), 32'(v.we1));
      if (v.we) chk({nm, ".wdata1"}, wd1, v.wd1);
    end
    if (v.en_cnt == 2) chk({nm, ".we2"}, 32'(w2), 32'(v.we2));
    @(negedge clk);
    chk({nm, ".rsp_clear"}, {rsp_valid, rsp_err, 30'd0} | rsp_rdata, 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'(req_ready) | 32'(rsp_valid) | 32'(rsp_err) | rsp_rdata | 32'(ram_en) |
           32'(ram_we) | 32'(ram_addr) | ram_wdata;
  endfunction

  initial begin
    logic seen;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;

    //      we size u addr          wdata          err lat en a1      we1   we2   wd1            rdata
    vt.push_back(mk(1, 2'd2, 0, 32'h10,   32'hDEADBEEF, 0, 2, 1, 12'h4,   4'hF, 4'h0, 32'hDEADBEEF, 32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h10,   32'h0,        0, 3, 1, 12'h4,   4'h0, 4'h0, 32'h0,        32'hDEADBEEF));
    vt.push_back(mk(1, 2'd0, 0, 32'h13,   32'h00000080, 0, 2, 1, 12'h4,   4'h8, 4'h0, 32'h80000000, 32'h0));
    vt.push_back(mk(0, 2'd0, 0, 32'h13,   32'h0,        0, 3, 1, 12'h4,   4'h0, 4'h0, 32'h0,        32'hFFFFFF80));
    vt.push_back(mk(0, 2'd0, 1, 32'h13,   32'h0,        0, 3, 1, 12'h4,   4'h0, 4'h0, 32'h0,        32'h00000080));
    vt.push_back(mk(0, 2'd1, 0, 32'h12,   32'h0,        0, 3, 1, 12'h4,   4'h0, 4'h0, 32'h0,        32'hFFFF80AD));
    vt.push_back(mk(0, 2'd1, 1, 32'h10,   32'h0,        0, 3, 1, 12'h4,   4'h0, 4'h0, 32'h0,        32'h0000BEEF));
    vt.push_back(mk(0, 2'd0, 0, 32'h10,   32'h0,        0, 3, 1, 12'h4,   4'h0, 4'h0, 32'h0,        32'hFFFFFFEF));
    vt.push_back(mk(0, 2'd3, 0, 32'h10,   32'h0,        1, 1, 0, 12'h0,   4'h0, 4'h0, 32'h0,        32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h4000, 32'h0,        1, 1, 0, 12'h0,   4'h0, 4'h0, 32'h0,        32'h0));
`ifdef MISALIGN_SPLIT_EN
    vt.push_back(mk(1, 2'd2, 0, 32'h21,   32'h11223344, 0, 3, 2, 12'h8,   4'hE, 4'h1, 32'h22334411, 32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h21,   32'h0,        0, 4, 2, 12'h8,   4'h0, 4'h0, 32'h0,        32'h11223344));
    vt.push_back(mk(0, 2'd2, 0, 32'h3FFD, 32'h0,        1, 1, 0, 12'h0,   4'h0, 4'h0, 32'h0,        32'h0));
    vt.push_back(mk(0, 2'd1, 0, 32'h11,   32'h0,        0, 3, 1, 12'h4,   4'h0, 4'h0, 32'h0,        32'hFFFFADBE));
    vt.push_back(mk(1, 2'd1, 0, 32'h23,   32'h0000A55A, 0, 3, 2, 12'h8,   4'h8, 4'h1, 32'h5A0000A5, 32'h0));
    vt.push_back(mk(0, 2'd1, 1, 32'h23,   32'h0,        0, 4, 2, 12'h8,   4'h0, 4'h0, 32'h0,        32'h0000A55A));
`else
    vt.push_back(mk(1, 2'd2, 0, 32'h21,   32'h11223344, 1, 1, 0, 12'h0,   4'h0, 4'h0, 32'h0,        32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h21,   32'h0,        1, 1, 0, 12'h0,   4'h0, 4'h0, 32'h0,        32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h3FFD, 32'h0,        1, 1, 0, 12'h0,   4'h0, 4'h0, 32'h0,        32'h0));
    vt.push_back(mk(0, 2'd1, 0, 32'h11,   32'h0,        1, 1, 0, 12'h0,   4'h0, 4'h0, 32'h0,        32'h0));
    vt.push_back(mk(1, 2'd1, 0, 32'h23,   32'h0000A55A, 1, 1, 0, 12'h0,   4'h0, 4'h0, 32'h0,        32'h0));
    vt.push_back(mk(0, 2'd1, 1, 32'h23,   32'h0,        1, 1, 0, 12'h0,   4'h0, 4'h0, 32'h0,        32'h0));
`endif
    vt.push_back(mk(1, 2'd1, 0, 32'h12,   32'hFFFF1234, 0, 2, 1, 12'h4,   4'hC, 4'h0, 32'h1234FFFF, 32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h10,   32'h0,        0, 3, 1, 12'h4,   4'h0, 4'h0, 32'h0,        32'h1234BEEF));
    vt.push_back(mk(0, 2'd0, 0, 32'h3FFF, 32'h0,        0, 3, 1, 12'hFFF, 4'h0, 4'h0, 32'h0,        32'h0));

    @(negedge clk);
    @(negedge clk);
    chk("reset.outs", all_outs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.ready_after", 32'(req_ready), 32'd1);

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    // Reset during the first access cycle of a load abandons it.
    wait_ready("rst_mid");
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_mid.outs_t1", all_outs(), 32'd0);
    @(negedge clk);
    chk("rst_mid.outs_t2", all_outs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.ready_after", 32'(req_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid || ram_en) seen = 1'b1;
      @(negedge clk);
    end
    chk("rst_mid.no_rsp", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the core's memory stage and the 4096×32 data RAM. It accepts one byte-addressed request per transaction and derives the RAM word index as byte address bits [AW+1:2]. It generates byte-lane write enables with lane-rotated store data, and aligns and sign- or zero-extends load data. Results return as a single-cycle response pulse, with errors flagged for illegal sizes, out-of-range addresses and misalignment.

## Interface
- AW, 12, RAM word-index width; RAM depth 2^AW words
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  qualifies rsp_valid; no RAM write occurred
- rsp_rdata  out  32  load result; 0 for stores and errors
- ram_en  out  1  RAM access strobe
- ram_we  out  4  byte-lane write enables; 0000 for reads
- ram_addr  out  AW  word index
- ram_wdata  out  32  lane-rotated store data
- ram_rdata  in  32  read data, valid exactly one cycle after ram_en

## Operation
- **Accept:** a request is accepted when req_valid and req_ready are both high. All request fields are latched. off = addr[1:0], k = addr[AW+1:2].
- **Error checks at accept** (the request goes straight to RESP with rsp_err = 1):
  - size == 11
  - addr[31:AW+2] != 0
  - misaligned: half with off[0] = 1, or word with off != 0
- **States:**
  - IDLE: on a good request → ACC1.
  - ACC1: access word k; ram_en = 1. Next state: ACC2 if split, else WAIT for a load, else RESP.
  - ACC2: access word k+1; capture ram_rdata as word0. Next state: WAIT for a load, else RESP.
  - WAIT: capture word0, or word1 if split.
  - RESP: rsp_valid = 1 for one cycle → IDLE.
- **Output gating:** ram_* outputs are driven from state and latched registers only, never combinationally from req_*. ram_en is forced to 0 in any cycle rst is high.
- **Store lanes:**
  - mask = 0001 / 0011 / 1111 for byte / half / word.
  - E = mask << off (7 bits wide).
  - ACC1 ram_we = E[3:0]; ACC2 ram_we = E[6:4].
  - ram_wdata = req_wdata rotated left by 8·off in both cycles.
- **Load assembly:**
  - Form {word1, word0} (word1 = 0 when not split) and shift right by 8·off.
  - Take bits [7:0], [15:0] or [31:0] according to size, then extend per req_unsigned.
  - Register the result into rsp_rdata when entering RESP.
- **Reset:**
  - All outputs are 0, state is IDLE, req_ready = 0 while rst is high.
  - Reset mid-transaction abandons the transaction with no response. Any ACC2 write not yet issued is dropped.

## Timing
- T = accept cycle.
- Aligned load: ram_en at T+1, rsp_valid at T+3.
- Aligned store: write at T+1, rsp_valid at T+2.
- Error: rsp_valid with rsp_err at T+1, no ram_en.
- Split load: ram_en at T+1 and T+2, rsp_valid at T+4.
- Split store: writes at T+1 and T+2, rsp_valid at T+3.
- req_ready is low from T+1 through the RESP cycle. The next accept is possible one cycle after RESP.
- rsp_rdata and rsp_err are valid only with rsp_valid and return to 0 in the following cycle.

## Configuration
- Macro: MISALIGN_SPLIT_EN.
- **Undefined:** every misaligned access is an error (rules above). ACC2 is unreachable and may be optimised out.
- **Defined:** misalignment is not an error.
  - Accesses with off + bytes ≤ 4 use a single access.
  - Half with off = 3, and word with off ≠ 0, split into ACC1 (word k) and ACC2 (word k+1).
  - A split with k = 2^AW − 1 is an error, with no access to either word.

## Test plan
- **Store/load word:** store word 0xDEADBEEF @0x0000_0010, then load word @0x10 → ram_addr = 4, ram_we = 1111 at T+1; rsp_rdata = 0xDEADBEEF at T+3.
- **Byte lanes and extension:**
  - Store byte 0x80 @0x13 → ram_we = 1000, ram_wdata = 0x80xxxxxx.
  - Load byte signed @0x13 → 0xFFFFFF80; unsigned → 0x00000080.
- **Errors:**
  - size = 11 → rsp_err at T+1.
  - addr 0x0000_4000 → rsp_err at T+1, ram_en never high.
- **Misaligned word @0x21:**
  - Macro undefined → rsp_err at T+1.
  - Macro defined, store 0x11223344 → ram_addr 8 with we 1110, then ram_addr 9 with we 0001, rsp at T+3.
  - Load back → 0x11223344 at T+4.
- **Split wrap (macro defined):** word @0x3FFD → rsp_err, no ram_en.
- **Reset mid-load:**
  - rst high in the cycle after accept → no rsp_valid.
  - All outputs 0 and req_ready = 0 during reset.
  - req_ready = 1 the cycle after rst drops.
